// File: rtl/display_scan_ctrl.sv
// Multiplexed display scanner: a prescaler steps through digit slots, and a
// frame-boundary shadow load keeps the displayed data stable for a whole frame.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SYM_W      = 3,
  parameter int DIV_LOG2   = 10,
  parameter int BLANK      = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [NUM_DIGITS*SYM_W-1:0] game_status,
  input  logic [NUM_DIGITS-1:0]       digit_enable,
  input  logic [2:0]                  brightness,
  output logic [NUM_DIGITS-1:0]       digit_select,
  output logic [SYM_W-1:0]            seven_seg,
  output logic                        frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_LOG2-1:0] P_MAX   = '1;
  localparam logic [DIV_LOG2-1:0] BLANK_P = DIV_LOG2'(BLANK);
  localparam logic [IDX_W-1:0]    I_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_LOG2-1:0]         p;
  logic [IDX_W-1:0]            i;
  logic [NUM_DIGITS*SYM_W-1:0] sh_status;
  logic [NUM_DIGITS-1:0]       sh_enable;
  logic [2:0]                  sh_bright;

  logic                  p_wrap;
  logic                  frame_end;
  logic                  lit;
  logic                  en_cur;
  logic [SYM_W-1:0]      sym_cur;
  logic [NUM_DIGITS-1:0] sel_next;
  logic [SYM_W-1:0]      seg_next;

  assign p_wrap    = (p == P_MAX);
  assign frame_end = p_wrap && (i == I_LAST);

  // PWM compares the top three prescaler bits against the shadowed level.
  always_comb begin
    en_cur  = 1'b0;
    sym_cur = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(i)) begin
        en_cur  = sh_enable[k];
        sym_cur = sh_status[k*SYM_W +: SYM_W];
      end
    end
    lit = (p >= BLANK_P) && en_cur && (p[DIV_LOG2-1 -: 3] <= sh_bright);
  end

  always_comb begin
    sel_next = '1;
    seg_next = '0;
    if (lit) begin
      seg_next = sym_cur;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (k == int'(i)) sel_next[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      p            <= '0;
      i            <= '0;
      sh_status    <= '0;
      sh_enable    <= '0;
      sh_bright    <= 3'd7;
      digit_select <= '1;
      seven_seg    <= '0;
      frame_start  <= 1'b0;
    end else begin
      p            <= p + 1'b1;
      digit_select <= sel_next;
      seven_seg    <= seg_next;
      frame_start  <= frame_end;
      if (p_wrap) begin
        i <= (i == I_LAST) ? '0 : i + 1'b1;
      end
      if (frame_end) begin
        sh_status <= game_status;
        sh_enable <= digit_enable;
        sh_bright <= brightness;
      end
    end
  end

endmodule
